// File: rtl/reflet_float_pkg.sv
// rtl/reflet_float_pkg.sv - shared definitions for the Reflet FPU multiply path
// Purpose: state encoding of the iterative mantissa multiplier and a helper
//          that reports its latency (cycles from accept to done), so that
//          consumers stay in step with the selected build.
// Build option: REFLET_FLOAT_MULT_RADIX4_EN selects the radix-4 latency.
package reflet_float_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } mult_state_e;

  // Cycle in which done is seen, counting the cycle after the accept edge as 1.
  function automatic int mult_iter_latency(input int size);
`ifdef REFLET_FLOAT_MULT_RADIX4_EN
    return (size + 1) / 2 + 1;
`else
    return size + 1;
`endif
  endfunction

endpackage

// File: rtl/reflet_float_mult_iter_step.sv
// rtl/reflet_float_mult_iter_step.sv - one combinational shift-add iteration
// Purpose: computes the next accumulator value from the current accumulator,
//          the multiplicand and the low multiplier bits.
// Ports:   acc      - current accumulator, 2*W bits
//          a        - multiplicand, W bits
//          a3       - 3*multiplicand, W+2 bits (radix-4 build only)
//          b_lo     - low multiplier bit(s): 1 bit radix-2, 2 bits radix-4
//          acc_next - accumulator after add and right shift
// Build option: REFLET_FLOAT_MULT_RADIX4_EN retires two multiplier bits.
module reflet_float_mult_iter_step #(
  parameter int W = 24
) (
  input  logic [2*W-1:0] acc,
  input  logic [W-1:0]   a,
`ifdef REFLET_FLOAT_MULT_RADIX4_EN
  input  logic [W+1:0]   a3,
  input  logic [1:0]     b_lo,
`else
  input  logic           b_lo,
`endif
  output logic [2*W-1:0] acc_next
);

  localparam int AW = 2 * W;

`ifdef REFLET_FLOAT_MULT_RADIX4_EN
  logic [W+1:0] addend;
  logic [W+1:0] sum;

  always_comb begin
    addend = '0;
    unique case (b_lo)
      2'd1:    addend = {2'b00, a};
      2'd2:    addend = {1'b0, a, 1'b0};
      2'd3:    addend = a3;
      default: addend = '0;
    endcase
  end

  // Upper half plus up to 3A stays below 2^(W+2), so the sum never overflows.
  assign sum      = {2'b00, acc[2*W-1:W]} + addend;
  assign acc_next = AW'({sum, acc[W-1:0]} >> 2);
`else
  logic [W:0] sum;

  // The carry out of the add becomes the new accumulator MSB after the shift.
  assign sum      = {1'b0, acc[2*W-1:W]} + (b_lo ? {1'b0, a} : '0);
  assign acc_next = AW'({sum, acc[W-1:0]} >> 1);
`endif

endmodule

// File: rtl/reflet_float_mult_iter.sv
// rtl/reflet_float_mult_iter.sv - iterative mantissa multiplier, start/done handshake
// Purpose: exact unsigned product of two mantissas (hidden bit included),
//          one shift-add iteration per cycle, for the float multiply stage.
// Ports:   clk     - rising-edge clock
//          reset   - asynchronous reset, active low
//          start   - request a multiply, sampled only while idle
//          in1     - multiplicand, captured on an accepted start
//          in2     - multiplier, captured on an accepted start
//          busy    - high from the cycle after accept through done
//          done    - one-cycle pulse, product valid from this cycle on
//          product - in1*in2, 2*size bits, held until the next result
// Build option: REFLET_FLOAT_MULT_RADIX4_EN retires two multiplier bits per cycle.
module reflet_float_mult_iter
  import reflet_float_pkg::*;
#(
  parameter int size = 24
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [size-1:0]   in1,
  input  logic [size-1:0]   in2,
  output logic              busy,
  output logic              done,
  output logic [2*size-1:0] product
);

`ifdef REFLET_FLOAT_MULT_RADIX4_EN
  // Odd widths are zero-extended so every iteration consumes a full bit pair.
  localparam int SE    = size + (size % 2);
  localparam int STEP  = 2;
  localparam int NITER = SE / 2;
`else
  localparam int SE    = size;
  localparam int STEP  = 1;
  localparam int NITER = size;
`endif
  localparam int CW = $clog2(size) + 1;
  localparam int PW = 2 * size;
  localparam logic [CW-1:0] CNT_LOAD = CW'(NITER - 1);

  mult_state_e state_q, state_d;

  logic [SE-1:0]   a_q;
  logic [SE-1:0]   b_q;
  logic [2*SE-1:0] acc_q;
  logic [2*SE-1:0] acc_next;
  logic [CW-1:0]   cnt_q;
  logic [PW-1:0]   product_q;
  logic [SE-1:0]   in1_ext;
  logic [SE-1:0]   in2_ext;

  assign in1_ext = SE'(in1);
  assign in2_ext = SE'(in2);

`ifdef REFLET_FLOAT_MULT_RADIX4_EN
  logic [SE+1:0] a3_q;
  logic [SE+1:0] in1_x3;

  assign in1_x3 = {2'b00, in1_ext} + {1'b0, in1_ext, 1'b0};
`endif

  reflet_float_mult_iter_step #(
    .W (SE)
  ) u_step (
    .acc      (acc_q),
    .a        (a_q),
`ifdef REFLET_FLOAT_MULT_RADIX4_EN
    .a3       (a3_q),
    .b_lo     (b_q[1:0]),
`else
    .b_lo     (b_q[0]),
`endif
    .acc_next (acc_next)
  );

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic: the iteration with counter 0 is the last one.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (start)        state_d = ST_RUN;
      ST_RUN:  if (cnt_q == '0)  state_d = ST_DONE;
      ST_DONE:                   state_d = ST_IDLE;
      default:                   state_d = ST_IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    busy = (state_q != ST_IDLE);
    done = (state_q == ST_DONE);
  end

  assign product = product_q;

  // Datapath
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_q       <= '0;
      b_q       <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      product_q <= '0;
`ifdef REFLET_FLOAT_MULT_RADIX4_EN
      a3_q      <= '0;
`endif
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (start) begin
            a_q   <= in1_ext;
            b_q   <= in2_ext;
            acc_q <= '0;
            cnt_q <= CNT_LOAD;
`ifdef REFLET_FLOAT_MULT_RADIX4_EN
            a3_q  <= in1_x3;
`endif
          end
        end
        ST_RUN: begin
          acc_q <= acc_next;
          b_q   <= b_q >> STEP;
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
          end else begin
            // Final iteration: publish the completed product on entry to DONE.
            product_q <= PW'(acc_next);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_reflet_float_mult_iter.sv
// tb/tb_reflet_float_mult_iter.sv - self-checking bench for reflet_float_mult_iter
module tb_reflet_float_mult_iter;
  import reflet_float_pkg::*;

  localparam int SIZE = 24;
  localparam int LAT  = mult_iter_latency(SIZE);
`ifdef REFLET_FLOAT_MULT_RADIX4_EN
  localparam int LAT_LIT = 13;
`else
  localparam int LAT_LIT = 25;
`endif

  logic              clk;
  logic              reset;
  logic              start;
  logic [SIZE-1:0]   in1;
  logic [SIZE-1:0]   in2;
  logic              busy;
  logic              done;
  logic [2*SIZE-1:0] product;

  int checks = 0;
  int errors = 0;

  reflet_float_mult_iter #(.size(SIZE)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .in1     (in1),
    .in2     (in2),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Timeline model: m_k counts cycles since the accept edge (0 = idle).
  int              m_k = 0;
  logic [2*SIZE-1:0] m_pend = '0;
  logic [2*SIZE-1:0] m_prod = '0;
  logic            m_busy;
  logic            m_done;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_k    <= 0;
      m_prod <= '0;
    end else if (m_k == 0) begin
      if (start) begin
        m_k    <= 1;
        m_pend <= (2*SIZE)'(in1) * (2*SIZE)'(in2);
      end
    end else if (m_k == LAT) begin
      m_k <= 0;
    end else begin
      m_k <= m_k + 1;
      if (m_k + 1 == LAT) m_prod <= m_pend;
    end
  end

  assign m_busy = (m_k != 0);
  assign m_done = (m_k == LAT);

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Cycle-by-cycle compare against the model.
  initial begin
    forever begin
      @(negedge clk);
      check("busy", 64'(busy), 64'(m_busy));
      check("done", 64'(done), 64'(m_done));
      check("product", 64'(product), 64'(m_prod));
    end
  end

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_idle"}, 64'(busy), 64'(0));
  endtask

  task automatic run_op(input logic [SIZE-1:0] a, input logic [SIZE-1:0] b,
                        input logic [2*SIZE-1:0] exp, input string tag);
    int n;
    wait_idle(tag);
    @(negedge clk);
    start = 1'b1;
    in1   = a;
    in2   = b;
    @(negedge clk);
    start = 1'b0;
    n = 1;
    while (!done && n < 200) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_lat"}, 64'(n), 64'(LAT_LIT));
    check({tag, "_prod"}, 64'(product), 64'(exp));
    @(negedge clk);
    check({tag, "_pulse"}, 64'(done), 64'(0));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [SIZE-1:0] ra, rb;

    reset = 1'b0;
    start = 1'b0;
    in1   = '0;
    in2   = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_product", 64'(product), 64'(0));
    #2 reset = 1'b1;
    @(negedge clk);

    run_op(24'h800000, 24'h800000, 48'h400000000000, "one");
    check("one_msb", 64'(product[2*SIZE-1]), 64'(0));
    run_op(24'hC00000, 24'hC00000, 48'h900000000000, "onehalf");
    check("onehalf_msb", 64'(product[2*SIZE-1]), 64'(1));
    run_op(24'hFFFFFF, 24'hFFFFFF, 48'hFFFFFE000001, "max");
    run_op(24'h000000, 24'hABCDEF, 48'h0, "zero");

    // start while busy is ignored; held start is accepted on return to idle
    wait_idle("ign");
    @(negedge clk);
    start = 1'b1;
    in1   = 24'hC00000;
    in2   = 24'hC00000;
    @(negedge clk);
    start = 1'b0;
    n = 1;
    repeat (5) begin
      @(negedge clk);
      n++;
    end
    start = 1'b1;
    in1   = 24'h123456;
    in2   = 24'h654321;
    while (!done && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("ign_lat", 64'(n), 64'(LAT_LIT));
    check("ign_prod", 64'(product), 64'(48'h900000000000));
    @(negedge clk);
    n = 1;
    while (!done && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("held_spacing", 64'(n), 64'(LAT_LIT + 1));
    check("held_prod", 64'(product), 64'(48'h123456) * 64'(48'h654321));
    start = 1'b0;
    @(negedge clk);

    // Asynchronous reset in the middle of RUN
    wait_idle("rstmid");
    @(negedge clk);
    start = 1'b1;
    in1   = 24'hFFFFFF;
    in2   = 24'hFFFFFF;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check("rstmid_busy", 64'(busy), 64'(0));
    check("rstmid_done", 64'(done), 64'(0));
    check("rstmid_product", 64'(product), 64'(0));
    repeat (2) @(negedge clk);
    #2 reset = 1'b1;
    @(negedge clk);
    run_op(24'h800001, 24'h800000, 48'h400000800000, "postrst");

    // Randomised operands, mostly normalised mantissas, some raw
    for (int i = 0; i < 1000; i++) begin
      ra = SIZE'($urandom);
      rb = SIZE'($urandom);
      if ($urandom_range(0, 3) != 0) ra[SIZE-1] = 1'b1;
      if ($urandom_range(0, 3) != 0) rb[SIZE-1] = 1'b1;
      run_op(ra, rb, (2*SIZE)'(ra) * (2*SIZE)'(rb), "rand");
    end

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
